// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
//
// Purpose: fetches instruction words from program memory (PMEM) at
// sequential word addresses, buffers them in a small FIFO and presents
// them with their PC to the decode stage over a valid/ready handshake.
// A redirect flushes buffered words and restarts fetch at a new address.
// At most one PMEM request is outstanding at any time.
//
// Optional feature macro: IFU_MISALIGN_CHECK_EN
//   defined   : a redirect to a non-word-aligned address raises
//               fetch_misaligned and halts fetching until an aligned
//               redirect arrives.
//   undefined : the low two bits of redirect_pc are ignored and
//               fetch_misaligned is tied to 0.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   pmem_req/pmem_addr  fetch request and byte address to PMEM
//   pmem_ack/pmem_rdata PMEM accept; read data valid in the ack cycle
//   instr/instr_pc      FIFO head word and its PC (zero when empty)
//   instr_valid         FIFO head is valid
//   instr_ready         decoder consumes the head this cycle
//   redirect/redirect_pc flush and restart fetch at redirect_pc
//   fetch_misaligned    misaligned redirect trapped (macro only)

module instruction_fetch_unit #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  pmem_req,
  output logic [ADDR_WIDTH-1:0] pmem_addr,
  input  logic                  pmem_ack,
  input  logic [31:0]           pmem_rdata,
  output logic [31:0]           instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  fetch_misaligned
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_FLUSH = 2'd1;
`ifdef IFU_MISALIGN_CHECK_EN
  localparam logic [1:0] ST_HALT  = 2'd2;
`endif

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [ADDR_WIDTH-1:0] hold_addr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [CNT_W-1:0]      count;

  logic [31:0]           fifo_instr [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_pc    [FIFO_DEPTH];

  logic                  push;
  logic                  pop;
  logic [ADDR_WIDTH-1:0] redirect_target;
  logic [1:0]            state_after_redirect;
  logic [1:0]            state_after_flush;

  // Request generation. The request only depends on state and count, and
  // count can only rise on an ack, so an unacknowledged request never drops.
  always_comb begin
    pmem_req  = 1'b0;
    pmem_addr = fetch_pc;
    case (state)
      ST_FETCH: pmem_req = (count < CNT_W'(FIFO_DEPTH));
      ST_FLUSH: begin
        pmem_req  = 1'b1;
        pmem_addr = hold_addr;
      end
      default: pmem_req = 1'b0;
    endcase
  end

  // Redirect wins over both push and pop; data returned in FLUSH is dropped.
  assign push = (state == ST_FETCH) & pmem_req & pmem_ack & ~redirect;
  assign pop  = instr_valid & instr_ready & ~redirect;

  assign instr_valid = (count != '0);
  assign instr       = instr_valid ? fifo_instr[rd_ptr] : '0;
  assign instr_pc    = instr_valid ? fifo_pc[rd_ptr]    : '0;

`ifdef IFU_MISALIGN_CHECK_EN
  logic misaligned_q;
  logic misaligned_target;

  assign misaligned_target    = |redirect_pc[1:0];
  assign redirect_target      = redirect_pc;
  assign state_after_redirect = misaligned_target ? ST_HALT : ST_FETCH;
  assign state_after_flush    = misaligned_q ? ST_HALT : ST_FETCH;
  assign fetch_misaligned     = misaligned_q;

  // Every redirect re-evaluates the trap flag, so an aligned one clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misaligned_q <= 1'b0;
    end else if (redirect) begin
      misaligned_q <= misaligned_target;
    end
  end
`else
  logic unused_redirect_low;

  assign unused_redirect_low  = ^redirect_pc[1:0];
  assign redirect_target      = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
  assign state_after_redirect = ST_FETCH;
  assign state_after_flush    = ST_FETCH;
  assign fetch_misaligned     = 1'b0;
`endif

  // Fetch control: PC advance, FLUSH entry/exit and redirect handling.
  // A redirect arriving while a request waits for its ack captures the
  // in-flight address so the request stays stable until PMEM accepts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_FETCH;
      fetch_pc  <= RESET_PC;
      hold_addr <= '0;
    end else if (redirect) begin
      fetch_pc <= redirect_target;
      if (pmem_req && !pmem_ack) begin
        hold_addr <= pmem_addr;
        state     <= ST_FLUSH;
      end else begin
        state <= state_after_redirect;
      end
    end else begin
      case (state)
        ST_FETCH: begin
          if (push) begin
            fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
          end
        end
        ST_FLUSH: begin
          if (pmem_ack) begin
            state <= state_after_flush;
          end
        end
        default: state <= state;
      endcase
    end
  end

  // FIFO pointers and occupancy; a redirect empties the buffer outright.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage needs no reset: entries are only visible while counted.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr[wr_ptr] <= pmem_rdata;
      fifo_pc[wr_ptr]    <= fetch_pc;
    end
  end

endmodule
